// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event arbiter.
package btn_evt_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_e;

   // Round-robin pick: first set bit of req[n-1:0] searching upward from last+1, wrapping at n.
   // Sized for the largest supported request count (16); callers zero-extend.
   // Returns last when nothing is requested.
   function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                          input logic [3:0]  last,
                                          input logic [4:0]  n);
      logic [4:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         idx = {1'b0, last} + 5'(k);
         if (idx >= n) idx = idx - n;
         if (!found && (5'(k) <= n) && req[idx[3:0]]) begin
            rr_pick = idx[3:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/btn_lockout_timer.sv
// One input slot: re-trigger lockout counter plus pending and sticky overflow bits.
module btn_lockout_timer #(
   parameter int LOCKOUT = 1023
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic pulse_i,
   input  logic grant_clr_i,
   input  logic clr_ovf_i,
   output logic pending_o,
   output logic pending_d_o,
   output logic overflow_o
);

   logic locked, accept;
   logic pend_q, pend_d;
   logic ovf_q, ovf_d;

   assign accept = pulse_i & ~locked;

   generate
      if (LOCKOUT > 0) begin : g_lock
         localparam int CNT_W = $clog2(LOCKOUT + 1);
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // reload on an accepted pulse, otherwise count down and stick at zero
         always_comb begin
            cnt_d = cnt_q;
            if (accept)             cnt_d = CNT_W'(LOCKOUT);
            else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
         end

         // lockout counter register
         always_ff @(posedge clk_i or negedge resetn_i) begin
            if (!resetn_i) cnt_q <= '0;
            else           cnt_q <= cnt_d;
         end

         assign locked = (cnt_q != '0);
      end else begin : g_nolock
         assign locked = 1'b0;
      end
   endgenerate

   // a pulse landing on a still-pending slot flags overflow; a handshake clear makes room first
   always_comb begin
      pend_d = (pend_q & ~grant_clr_i) | accept;
      ovf_d  = (ovf_q & ~clr_ovf_i) | (accept & pend_q & ~grant_clr_i);
   end

   // pending / overflow registers
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         pend_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pending_o   = pend_q;
   assign pending_d_o = pend_d;
   assign overflow_o  = ovf_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Latches debounced button pulses and round-robins them into one valid/ready event stream.
module button_event_arbiter
   import btn_evt_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int LOCKOUT = 1023,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic [NUM_REQ-1:0] pulse_i,
   output logic               evt_valid_o,
   input  logic               evt_ready_i,
   output logic [ID_W-1:0]    evt_id_o,
   output logic               irq_o,
   output logic [NUM_REQ-1:0] pending_o,
   output logic [NUM_REQ-1:0] overflow_o,
   input  logic               clr_overflow_i
);

   arb_state_e         state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic               irq_q, irq_d;
   logic [NUM_REQ-1:0] pend, pend_nx, ovf;
   logic               hs;

   assign hs = (state_q == OFFER) & evt_ready_i;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      btn_lockout_timer #(.LOCKOUT(LOCKOUT)) u_timer (
         .clk_i       (clk_i),
         .resetn_i    (resetn_i),
         .pulse_i     (pulse_i[i]),
         .grant_clr_i (hs && (id_q == ID_W'(i))),
         .clr_ovf_i   (clr_overflow_i),
         .pending_o   (pend[i]),
         .pending_d_o (pend_nx[i]),
         .overflow_o  (ovf[i])
      );
   end

   // state and output registers; last grant starts at the top so input 0 wins first
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= IDLE;
         id_q    <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         last_q  <= last_d;
         irq_q   <= irq_d;
      end
   end

   // next state: one offer per pick, always returning through IDLE after a handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|pend)       state_d = OFFER;
         OFFER:   if (evt_ready_i) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // outputs: capture the winner when leaving IDLE, advance the pointer on handshake
   always_comb begin
      id_d   = id_q;
      last_d = last_q;
      if ((state_q == IDLE) && (|pend))
         id_d = ID_W'(rr_pick(16'(pend), 4'(last_q), 5'(NUM_REQ)));
      if (hs)
         last_d = id_q;
      irq_d = (|pend_nx) | (state_d == OFFER);
   end

   assign evt_valid_o = (state_q == OFFER);
   assign evt_id_o    = id_q;
   assign irq_o       = irq_q;
   assign pending_o   = pend;
   assign overflow_o  = ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench: two arbiters (lockout 8 and lockout 0) on shared inputs, checked against
// vector tables, directed corner sequences and a per-cycle behavioural model.
module tb_button_event_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk_i = 1'b0;
   logic          resetn_i = 1'b1;
   logic [N-1:0]  pulse_i = '0;
   logic          evt_ready_i = 1'b0;
   logic          clr_overflow_i = 1'b0;

   logic          v8, v0, irq8, irq0;
   logic [IW-1:0] id8, id0;
   logic [N-1:0]  pend8, pend0, ovf8, ovf0;

   always #5 clk_i = ~clk_i;

   button_event_arbiter #(.NUM_REQ(N), .LOCKOUT(8)) dut8 (
      .clk_i(clk_i), .resetn_i(resetn_i), .pulse_i(pulse_i),
      .evt_valid_o(v8), .evt_ready_i(evt_ready_i), .evt_id_o(id8),
      .irq_o(irq8), .pending_o(pend8), .overflow_o(ovf8),
      .clr_overflow_i(clr_overflow_i));

   button_event_arbiter #(.NUM_REQ(N), .LOCKOUT(0)) dut0 (
      .clk_i(clk_i), .resetn_i(resetn_i), .pulse_i(pulse_i),
      .evt_valid_o(v0), .evt_ready_i(evt_ready_i), .evt_id_o(id0),
      .irq_o(irq0), .pending_o(pend0), .overflow_o(ovf0),
      .clr_overflow_i(clr_overflow_i));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // ---------------- reference model (index 0: lockout 8, index 1: lockout 0)
   int  LK[2] = '{8, 0};
   int  m_lock[2][N];
   bit  m_pend[2][N];
   bit  m_ovf[2][N];
   bit  m_valid[2];
   int  m_id[2];
   int  m_last[2];
   bit  m_irq[2];

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < N; i++) begin
            m_lock[u][i] = 0; m_pend[u][i] = 0; m_ovf[u][i] = 0;
         end
         m_valid[u] = 0; m_id[u] = 0; m_last[u] = N - 1; m_irq[u] = 0;
      end
   endtask

   task automatic model_step(input int u);
      bit hs, clr, acc;
      int pick;
      hs   = m_valid[u] && evt_ready_i;
      pick = -1;
      for (int k = 1; k <= N; k++)
         if (pick < 0 && m_pend[u][(m_last[u] + k) % N]) pick = (m_last[u] + k) % N;
      for (int i = 0; i < N; i++) begin
         clr = hs && (m_id[u] == i);
         acc = pulse_i[i] && (m_lock[u][i] == 0);
         m_ovf[u][i]  = (m_ovf[u][i] && !clr_overflow_i) || (acc && m_pend[u][i] && !clr);
         m_pend[u][i] = (m_pend[u][i] && !clr) || acc;
         m_lock[u][i] = acc ? LK[u] : (m_lock[u][i] > 0 ? m_lock[u][i] - 1 : 0);
      end
      if (m_valid[u]) begin
         if (hs) begin m_last[u] = m_id[u]; m_valid[u] = 0; end
      end else if (pick >= 0) begin
         m_id[u] = pick; m_valid[u] = 1;
      end
      m_irq[u] = m_valid[u];
      for (int i = 0; i < N; i++) m_irq[u] |= m_pend[u][i];
   endtask

   function automatic logic [11:0] model_out(input int u);
      logic [N-1:0] p, o;
      for (int i = 0; i < N; i++) begin p[i] = m_pend[u][i]; o[i] = m_ovf[u][i]; end
      return {m_valid[u], IW'(m_id[u]), p, o, m_irq[u]};
   endfunction

   // one clock: inputs already driven; step model at the edge, compare 1 time unit later
   task automatic cycle();
      @(posedge clk_i);
      model_step(0);
      model_step(1);
      #1;
      check("model_lk8", {v8, id8, pend8, ovf8, irq8}, model_out(0));
      check("model_lk0", {v0, id0, pend0, ovf0, irq0}, model_out(1));
   endtask

   // asynchronous reset: outputs must drop before any clock edge
   task automatic do_reset();
      resetn_i = 1'b0; pulse_i = '0; evt_ready_i = 1'b0; clr_overflow_i = 1'b0;
      #1;
      check("rst_async_lk8", {v8, id8, pend8, ovf8, irq8}, 12'h0);
      check("rst_async_lk0", {v0, id0, pend0, ovf0, irq0}, 12'h0);
      model_reset();
      @(posedge clk_i);
      #1;
      resetn_i = 1'b1;
   endtask

   // ---------------- vector table
   typedef struct {
      bit            rst;
      logic [N-1:0]  pulse;
      logic          ready;
      logic          valid;
      logic [IW-1:0] id;
      logic [N-1:0]  pend;
      logic          irq;
   } vec_t;

   function automatic vec_t mk(bit r, logic [N-1:0] p, logic rd, logic v,
                               logic [IW-1:0] id, logic [N-1:0] pe, logic q);
      vec_t t;
      t.rst = r; t.pulse = p; t.ready = rd; t.valid = v; t.id = id; t.pend = pe; t.irq = q;
      return t;
   endfunction

   vec_t tbl[17];

   initial begin
      // single pulse on input 1, ready held high
      tbl[0]  = mk(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1);
      tbl[1]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);
      tbl[2]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);
      tbl[3]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);
      // all four together: 0,1,2,3 one every two cycles, then a second burst
      tbl[4]  = mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 1'b1);
      tbl[5]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
      tbl[6]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1110, 1'b1);
      tbl[7]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b1110, 1'b1);
      tbl[8]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b1100, 1'b1);
      tbl[9]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b1100, 1'b1);
      tbl[10] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b1);
      tbl[11] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1);
      tbl[12] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
      tbl[13] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 4'b1111, 1'b1);
      tbl[14] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
      tbl[15] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1110, 1'b1);
      tbl[16] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b1110, 1'b1);

      #2;
      for (int k = 0; k < 17; k++) begin
         if (tbl[k].rst) do_reset();
         pulse_i     = tbl[k].pulse;
         evt_ready_i = tbl[k].ready;
         cycle();
         check($sformatf("vec%0d", k), {v8, id8, pend8, irq8},
               {tbl[k].valid, tbl[k].id, tbl[k].pend, tbl[k].irq});
      end
      pulse_i = '0;

      // lockout 8: re-pulse at t+4 ignored without overflow, pulse at t+10 accepted
      do_reset();
      evt_ready_i = 1'b1;
      pulse_i = 4'b0001; cycle(); pulse_i = '0;
      repeat (3) cycle();
      pulse_i = 4'b0001; cycle(); pulse_i = '0;
      check("lock_discard_pend", pend8, 4'b0000);
      check("lock_discard_ovf", ovf8, 4'b0000);
      repeat (5) cycle();
      pulse_i = 4'b0001; cycle(); pulse_i = '0;
      check("lock_reaccept", pend8, 4'b0001);

      // no lockout: double pulse overflows, set beats clear, then clear alone
      do_reset();
      pulse_i = 4'b0100; cycle(); cycle(); pulse_i = '0;
      check("ovf_pend", pend0, 4'b0100);
      check("ovf_set", ovf0, 4'b0100);
      check("ovf_locked_none", ovf8, 4'b0000);
      pulse_i = 4'b0100; clr_overflow_i = 1'b1; cycle(); pulse_i = '0;
      check("ovf_set_wins", ovf0, 4'b0100);
      cycle(); clr_overflow_i = 1'b0;
      check("ovf_clr", ovf0, 4'b0000);
      check("ovf_clr_offer", {v0, id0}, {1'b1, 2'd2});

      // backpressure: offer of id 2 stays put while input 3 arrives
      pulse_i = 4'b1000; cycle(); pulse_i = '0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         check("bp_hold", {v0, id0}, {1'b1, 2'd2});
      end
      evt_ready_i = 1'b1; cycle();
      check("bp_bubble", v0, 1'b0);
      cycle();
      check("bp_next", {v0, id0}, {1'b1, 2'd3});

      // re-pulse of input 1 during its own handshake keeps it pending
      do_reset();
      pulse_i = 4'b0010; cycle(); pulse_i = '0;
      repeat (10) cycle();
      evt_ready_i = 1'b1; pulse_i = 4'b0010; cycle();
      pulse_i = '0; evt_ready_i = 1'b0;
      check("repulse_pend", pend8, 4'b0010);
      check("repulse_ovf", ovf8, 4'b0000);
      check("repulse_bubble", v8, 1'b0);
      cycle();
      check("repulse_offer", {v8, id8}, {1'b1, 2'd1});

      // reset while offering drops everything immediately
      do_reset();

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         pulse_i        = 4'($urandom) & 4'($urandom);
         evt_ready_i    = 1'($urandom);
         clr_overflow_i = ($urandom_range(0, 15) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
